dmem_unit: RTL and testbench
============================

# dmem_unit

Parametrised data-memory unit for the MEM stage of the 5-stage MIPS pipeline, sitting between the EX/MEM and MEM/WB pipeline registers. It performs little-endian byte/halfword/word stores and registered loads with signed or unsigned extension. It detects misaligned accesses and clears the array with a hardware sweep engine instead of a single-cycle reset, so the array maps onto block RAM. Control and ALU-result fields pass through to WB unchanged.

## Interface
- DEPTH_BYTES, 1024, memory size in bytes; power of two, ≥ 8, multiple of 4.
- ADDR_W, $clog2(DEPTH_BYTES), byte-address bits actually decoded.
- i_clk  in  1  clock; all state updates on rising edge.
- i_reset  in  1  reset i_reset, asynchronous, active-high; clock i_clk.
- i_addr  in  32  ALU result / effective byte address.
- i_wdata  in  32  store data; low bytes used for byte and halfword stores.
- i_rd  in  5  destination register ID.
- i_mem_read  in  1  load request.
- i_mem_write  in  1  store request.
- i_mem_to_reg  in  1  WB mux select, passed through.
- i_reg_write  in  1  WB register write enable, passed through.
- i_bhw_type  in  3  access size: 001 word, 010 halfword, 100 byte; other codes are invalid.
- i_unsigned  in  1  1 = zero-extend loads (lbu/lhu), 0 = sign-extend.
- i_clear  in  1  one-cycle pulse that starts a clear sweep.
- o_wb_read_data  out  32  registered load result.
- o_wb_alu_result  out  32  = i_addr, combinational.
- o_wb_rd, o_rd  out  5  = i_rd, combinational.
- o_wb_mem_to_reg, o_wb_reg_write  out  1  pass-through, combinational.
- o_misaligned  out  1  registered one-cycle pulse on a rejected misaligned access.
- o_busy  out  1  high while the clear sweep runs; the hazard unit stalls on it.

## Operation
- Address is i_addr[ADDR_W-1:0]. Upper bits are ignored, so addresses wrap modulo DEPTH_BYTES.
- Byte lanes are little-endian: byte at addr holds data[7:0], addr+1 holds data[15:8], and so on.
- Alignment rules:
  - Word requires addr[1:0]=0.
  - Halfword requires addr[0]=0.
  - Byte accesses are always aligned.
- A misaligned store is suppressed and a misaligned load leaves o_wb_read_data unchanged. Either one raises o_misaligned for the following cycle.
- Store: only the lanes for the access size are written. Other bytes of the word are preserved.
- Load extension:
  - Word: the 32-bit word.
  - Halfword: 16 bits, sign-extended from bit 15 unless i_unsigned.
  - Byte: 8 bits, sign-extended from bit 7 unless i_unsigned.
- Invalid i_bhw_type:
  - Store: no write.
  - Load: o_wb_read_data becomes 0.
  - o_misaligned is not raised.
- If i_mem_read and i_mem_write are both high, the write wins and o_wb_read_data holds.
- With no request, o_wb_read_data holds its previous value.
- Clear FSM, with states IDLE and CLEAR:
  - Reset forces CLEAR with the word pointer at 0.
  - IDLE → CLEAR on i_clear; the pointer resets to 0.
  - CLEAR writes 32'h0 to the word at the pointer each cycle and then increments the pointer.
  - After word DEPTH_BYTES/4-1 is written, the FSM returns to IDLE.
  - In CLEAR, i_mem_read, i_mem_write and i_clear are ignored.
- Reset asserted mid-sweep restarts the sweep from word 0.
- The array itself is never reset asynchronously; only the sweep zeroes it.

## Timing
- Reset values:
  - o_wb_read_data = 0
  - o_misaligned = 0
  - o_busy = 1
  - FSM = CLEAR, pointer = 0
- Pass-through outputs follow their inputs with no reset dependency.
- Load latency is 1 cycle: data is present in o_wb_read_data after the edge that samples i_mem_read.
- Store takes effect at the sampling edge. A load of the same address in the next cycle returns the new data.
- o_busy stays high for exactly DEPTH_BYTES/4 cycles after reset deassertion, and for DEPTH_BYTES/4 cycles after the edge that samples i_clear.
- o_busy is driven from the FSM state register and has no combinational path from the inputs.
- o_misaligned is high for exactly one cycle per offending request.

## Configuration
- DMEM_DEBUG_PORT_EN:
  - Defined: adds ports i_dbg_addr (in, ADDR_W-2, word index) and o_dbg_data (out, 32). o_dbg_data is the word at i_dbg_addr, registered with 1-cycle latency and reset to 0. The read is side-effect free, independent of pipeline accesses, and valid during a clear sweep; it then returns the current array contents.
  - Undefined: neither port exists and no extra read logic is built.

## Structure
- Shared package mips_pkg holds:
  - The BHW_WORD/BHW_HALF/BHW_BYTE constants (3'b001/3'b010/3'b100).
  - The clear-FSM state enum.
- Natural sub-module: dmem_byte_ram, a 4-lane byte-enable RAM of DEPTH_BYTES/4 words with synchronous write and registered read. dmem_unit contains the lane steering, extension, alignment check and clear FSM.

## Test plan
- Reset, then DEPTH_BYTES=1024 → o_busy high for exactly 256 cycles. A load of word 0x3FC afterwards returns 0.
- sw 0x8899AABB @0x10, then lb @0x12 → 0xFFFFFF99; lbu @0x12 → 0x00000099; lh @0x12 → 0xFFFF8899; lhu @0x10 → 0x0000AABB.
- sh 0x1234 @0x20 over a word holding 0xFFFFFFFF → lw @0x20 returns 0xFFFF1234.
- sw @0x22 → no write, o_misaligned pulses one cycle. lh @0x21 → o_wb_read_data holds its prior value, o_misaligned pulses.
- i_clear pulse after stores, plus a store issued during busy → the store is ignored. Every previously written word reads 0 after the 256 busy cycles.
- Address 0x404 with sw 0xCAFEF00D → lw @0x004 returns 0xCAFEF00D (wrap). With DMEM_DEBUG_PORT_EN, i_dbg_addr=1 gives o_dbg_data 0xCAFEF00D one cycle later.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS pipeline constants, clear-FSM state type and access-size helper
package mips_pkg;
  localparam logic [2:0] BHW_WORD = 3'b001;
  localparam logic [2:0] BHW_HALF = 3'b010;
  localparam logic [2:0] BHW_BYTE = 3'b100;
  typedef enum logic {CLR_IDLE, CLR_CLEAR} clr_state_t;
  function automatic logic bhw_valid(input logic [2:0] t);
    return t == BHW_WORD || t == BHW_HALF || t == BHW_BYTE;
  endfunction
endpackage

// File: rtl/dmem_byte_ram.sv
// dmem_byte_ram: 4-lane byte-enable RAM, synchronous write, registered read; DMEM_DEBUG_PORT_EN adds a read-only second port
module dmem_byte_ram #(
  parameter int WORDS = 256,
  parameter int AW = $clog2(WORDS)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
`ifdef DMEM_DEBUG_PORT_EN
  ,
  input  logic [AW-1:0] i_dbg_addr,
  output logic [31:0]   o_dbg_data
`endif
);
  logic [31:0] mem [WORDS];
  // Lane-masked write and registered read on the pipeline port; no reset so it maps onto block RAM
  always_ff @(posedge i_clk) begin
    if (i_we)
      for (int b = 0; b < 4; b++)
        if (i_be[b]) mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
    o_rdata <= mem[i_addr];
  end
`ifdef DMEM_DEBUG_PORT_EN
  // Independent registered read for the debug port
  always_ff @(posedge i_clk) o_dbg_data <= mem[i_dbg_addr];
`endif
endmodule

// File: rtl/dmem_unit.sv
// dmem_unit: MEM-stage data memory with lane steering, load extension, alignment check and clear sweep; DMEM_DEBUG_PORT_EN adds a debug read port
module dmem_unit
  import mips_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int ADDR_W = $clog2(DEPTH_BYTES)
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_rd,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic        i_mem_to_reg,
  input  logic        i_reg_write,
  input  logic [2:0]  i_bhw_type,
  input  logic        i_unsigned,
  input  logic        i_clear,
  output logic [31:0] o_wb_read_data,
  output logic [31:0] o_wb_alu_result,
  output logic [4:0]  o_wb_rd,
  output logic [4:0]  o_rd,
  output logic        o_wb_mem_to_reg,
  output logic        o_wb_reg_write,
  output logic        o_misaligned,
  output logic        o_busy
`ifdef DMEM_DEBUG_PORT_EN
  ,
  input  logic [ADDR_W-3:0] i_dbg_addr,
  output logic [31:0]       o_dbg_data
`endif
);
  localparam int WORDS = DEPTH_BYTES / 4;
  localparam int WA = ADDR_W - 2;
  localparam logic [WA-1:0] LAST = WA'(WORDS - 1);
  clr_state_t state_q, state_d;
  logic [WA-1:0] ptr_q, ptr_d;
  logic load_q, load_d, uns_q, uns_d, mis_q, mis_d;
  logic [2:0] size_q, size_d;
  logic [1:0] off_q, off_d;
  logic [31:0] hold_q, hold_d;
  logic [ADDR_W-1:0] a;
  logic [1:0] off;
  logic idle, mis, st, ld;
  logic ram_we;
  logic [3:0] ram_be;
  logic [WA-1:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata, ext;
  logic [15:0] shifted;
  logic unused_addr;
  assign unused_addr = ^i_addr[31:ADDR_W];
  assign o_wb_alu_result = i_addr;
  assign o_wb_rd = i_rd;
  assign o_rd = i_rd;
  assign o_wb_mem_to_reg = i_mem_to_reg;
  assign o_wb_reg_write = i_reg_write;
  assign o_busy = state_q == CLR_CLEAR;
  assign o_misaligned = mis_q;
  assign o_wb_read_data = hold_d;
  // Request decode, RAM port steering, sweep sequencing and load extension
  always_comb begin
    a = i_addr[ADDR_W-1:0];
    off = a[1:0];
    idle = state_q == CLR_IDLE;
    mis = (i_bhw_type == BHW_WORD && off != 2'b00) || (i_bhw_type == BHW_HALF && off[0]);
    st = idle && i_mem_write && bhw_valid(i_bhw_type) && !mis;
    ld = idle && i_mem_read && !i_mem_write && !mis;
    mis_d = idle && (i_mem_write || i_mem_read) && mis;
    ram_we = !idle || st;
    ram_addr = idle ? a[ADDR_W-1:2] : ptr_q;
    ram_be = !idle || i_bhw_type == BHW_WORD ? 4'hF : i_bhw_type == BHW_HALF ? 4'b0011 << off : 4'b0001 << off;
    ram_wdata = !idle ? 32'h0 : i_bhw_type == BHW_WORD ? i_wdata :
                i_bhw_type == BHW_HALF ? {2{i_wdata[15:0]}} : {4{i_wdata[7:0]}};
    state_d = idle ? (i_clear ? CLR_CLEAR : CLR_IDLE) : (ptr_q == LAST ? CLR_IDLE : CLR_CLEAR);
    ptr_d = idle ? '0 : ptr_q + WA'(1);
    load_d = ld;
    size_d = i_bhw_type;
    uns_d = i_unsigned;
    off_d = off;
    shifted = 16'(ram_rdata >> {off_q, 3'b000});
    ext = size_q == BHW_WORD ? ram_rdata :
          size_q == BHW_HALF ? {{16{~uns_q & shifted[15]}}, shifted} :
          size_q == BHW_BYTE ? {{24{~uns_q & shifted[7]}}, shifted[7:0]} : 32'h0;
    hold_d = load_q ? ext : hold_q;
  end
  // State and load-pipeline registers; reset restarts the sweep from word 0
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= CLR_CLEAR;
      ptr_q <= '0;
      load_q <= 1'b0;
      uns_q <= 1'b0;
      mis_q <= 1'b0;
      size_q <= 3'b000;
      off_q <= 2'b00;
      hold_q <= 32'h0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      load_q <= load_d;
      uns_q <= uns_d;
      mis_q <= mis_d;
      size_q <= size_d;
      off_q <= off_d;
      hold_q <= hold_d;
    end
  end
`ifdef DMEM_DEBUG_PORT_EN
  logic dbg_vld_q, dbg_vld_d;
  logic [31:0] ram_dbg;
  assign o_dbg_data = dbg_vld_q ? ram_dbg : 32'h0;
  // Debug output reads 0 until the first registered read after reset
  always_comb dbg_vld_d = 1'b1;
  // Debug valid flag
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) dbg_vld_q <= 1'b0;
    else dbg_vld_q <= dbg_vld_d;
  end
`endif
  dmem_byte_ram #(.WORDS(WORDS), .AW(WA)) u_ram (
    .i_clk(i_clk),
    .i_we(ram_we),
    .i_be(ram_be),
    .i_addr(ram_addr),
    .i_wdata(ram_wdata),
    .o_rdata(ram_rdata)
`ifdef DMEM_DEBUG_PORT_EN
    ,
    .i_dbg_addr(i_dbg_addr),
    .o_dbg_data(ram_dbg)
`endif
  );
endmodule

// File: tb/tb_dmem_unit.sv
// tb_dmem_unit: self-checking bench for dmem_unit against a byte-array reference model
module tb_dmem_unit;
  localparam int DB = 1024;
  logic i_clk = 1'b0;
  logic i_reset;
  logic [31:0] i_addr, i_wdata;
  logic [4:0] i_rd;
  logic i_mem_read, i_mem_write, i_mem_to_reg, i_reg_write, i_unsigned, i_clear;
  logic [2:0] i_bhw_type;
  logic [31:0] o_wb_read_data, o_wb_alu_result;
  logic [4:0] o_wb_rd, o_rd;
  logic o_wb_mem_to_reg, o_wb_reg_write, o_misaligned, o_busy;
`ifdef DMEM_DEBUG_PORT_EN
  logic [7:0] i_dbg_addr;
  logic [31:0] o_dbg_data;
`endif
  logic [7:0] m [DB];
  logic [31:0] exp_rd;
  logic exp_mis;
  int checks = 0, failures = 0;
  always #5 i_clk = ~i_clk;
  dmem_unit #(.DEPTH_BYTES(DB)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_addr(i_addr), .i_wdata(i_wdata), .i_rd(i_rd),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_mem_to_reg(i_mem_to_reg),
    .i_reg_write(i_reg_write), .i_bhw_type(i_bhw_type), .i_unsigned(i_unsigned), .i_clear(i_clear),
    .o_wb_read_data(o_wb_read_data), .o_wb_alu_result(o_wb_alu_result), .o_wb_rd(o_wb_rd), .o_rd(o_rd),
    .o_wb_mem_to_reg(o_wb_mem_to_reg), .o_wb_reg_write(o_wb_reg_write),
    .o_misaligned(o_misaligned), .o_busy(o_busy)
`ifdef DMEM_DEBUG_PORT_EN
    , .i_dbg_addr(i_dbg_addr), .o_dbg_data(o_dbg_data)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic cycle();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask
  task automatic op(input string tag, input bit wr, input bit rd, input logic [31:0] addr,
                    input logic [31:0] wd, input logic [2:0] t, input bit u);
    int a, sz;
    logic [31:0] v;
    logic [4:0] r;
    r = 5'($urandom);
    i_mem_write = wr; i_mem_read = rd; i_addr = addr; i_wdata = wd; i_bhw_type = t; i_unsigned = u;
    i_rd = r; i_mem_to_reg = rd; i_reg_write = ~wr;
    #1;
    chk({tag, ".alu"}, o_wb_alu_result, addr);
    chk({tag, ".rd"}, {o_rd, o_wb_rd, o_wb_mem_to_reg, o_wb_reg_write}, {r, r, rd, ~wr});
    a = int'(addr % DB);
    sz = t == 3'b001 ? 4 : t == 3'b010 ? 2 : t == 3'b100 ? 1 : 0;
    exp_mis = (wr || rd) && sz != 0 && (a % sz) != 0;
    if (wr) begin
      if (sz != 0 && !exp_mis)
        for (int i = 0; i < sz; i++) m[(a + i) % DB] = wd[8*i +: 8];
    end else if (rd && !exp_mis) begin
      v = 32'h0;
      for (int i = 0; i < sz; i++) v[8*i +: 8] = m[(a + i) % DB];
      if (!u && sz > 0 && sz < 4 && v[8*sz-1])
        for (int i = 8 * sz; i < 32; i++) v[i] = 1'b1;
      exp_rd = v;
    end
    cycle();
    i_mem_write = 1'b0; i_mem_read = 1'b0;
    chk({tag, ".data"}, o_wb_read_data, exp_rd);
    chk({tag, ".mis"}, {31'h0, o_misaligned}, {31'h0, exp_mis});
  endtask
  initial begin
    int n;
    logic [2:0] types [8];
    types = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b000, 3'b011};
    i_reset = 1'b1; i_addr = 0; i_wdata = 0; i_rd = 0; i_mem_read = 0; i_mem_write = 0;
    i_mem_to_reg = 0; i_reg_write = 0; i_bhw_type = 3'b001; i_unsigned = 0; i_clear = 0;
`ifdef DMEM_DEBUG_PORT_EN
    i_dbg_addr = 8'd0;
`endif
    for (int i = 0; i < DB; i++) m[i] = 8'h00;
    exp_rd = 32'h0;
    repeat (3) @(negedge i_clk);
    chk("rst_rdata", o_wb_read_data, 32'h0);
    chk("rst_mis", {31'h0, o_misaligned}, 32'h0);
    chk("rst_busy", {31'h0, o_busy}, 32'h1);
`ifdef DMEM_DEBUG_PORT_EN
    chk("rst_dbg", o_dbg_data, 32'h0);
`endif
    i_reset = 1'b0;
    n = 0;
    while (o_busy && n < 2000) begin cycle(); n++; end
    chk("reset_busy_cycles", n, 256);
    op("lw3fc", 0, 1, 32'h3FC, 0, 3'b001, 0);
    chk("lw3fc_zero", o_wb_read_data, 32'h0);
    op("sw10", 1, 0, 32'h10, 32'h8899AABB, 3'b001, 0);
    op("lb12", 0, 1, 32'h12, 0, 3'b100, 0);
    chk("lb12_const", o_wb_read_data, 32'hFFFFFF99);
    op("lbu12", 0, 1, 32'h12, 0, 3'b100, 1);
    chk("lbu12_const", o_wb_read_data, 32'h00000099);
    op("lh12", 0, 1, 32'h12, 0, 3'b010, 0);
    chk("lh12_const", o_wb_read_data, 32'hFFFF8899);
    op("lhu10", 0, 1, 32'h10, 0, 3'b010, 1);
    chk("lhu10_const", o_wb_read_data, 32'h0000AABB);
    op("sw20", 1, 0, 32'h20, 32'hFFFFFFFF, 3'b001, 0);
    op("sh20", 1, 0, 32'h20, 32'h00001234, 3'b010, 0);
    op("lw20", 0, 1, 32'h20, 0, 3'b001, 0);
    chk("lw20_const", o_wb_read_data, 32'hFFFF1234);
    op("sw22_mis", 1, 0, 32'h22, 32'hDEADBEEF, 3'b001, 0);
    op("idle1", 0, 0, 32'h0, 0, 3'b001, 0);
    op("lw20_again", 0, 1, 32'h20, 0, 3'b001, 0);
    op("lh21_mis", 0, 1, 32'h21, 0, 3'b010, 0);
    chk("lh21_hold", o_wb_read_data, 32'hFFFF1234);
    op("idle2", 0, 0, 32'h0, 0, 3'b001, 0);
    op("rw_both", 1, 1, 32'h24, 32'h13579BDF, 3'b001, 0);
    op("ld_inv", 0, 1, 32'h24, 0, 3'b011, 0);
    op("st_inv", 1, 0, 32'h24, 32'hFFFFFFFF, 3'b000, 0);
    op("lw24", 0, 1, 32'h24, 0, 3'b001, 0);
    op("sb_hi", 1, 0, 32'h27, 32'h000000A5, 3'b100, 0);
    op("lw24b", 0, 1, 32'h24, 0, 3'b001, 0);
    op("sw404", 1, 0, 32'h404, 32'hCAFEF00D, 3'b001, 0);
    op("lw004", 0, 1, 32'h004, 0, 3'b001, 0);
    chk("wrap_const", o_wb_read_data, 32'hCAFEF00D);
`ifdef DMEM_DEBUG_PORT_EN
    i_dbg_addr = 8'd1;
    cycle();
    chk("dbg_word1", o_dbg_data, 32'hCAFEF00D);
`endif
    for (int k = 0; k < 200; k++)
      op("rnd", 1'($urandom), 1'($urandom), ($urandom & 32'hFFFFFC00) | 32'($urandom_range(0, 63)),
         $urandom, types[$urandom_range(0, 7)], 1'($urandom));
    i_clear = 1'b1;
    cycle();
    i_clear = 1'b0;
    i_mem_write = 1'b1; i_addr = 32'h10; i_wdata = 32'h55555555; i_bhw_type = 3'b001;
    n = 0;
    while (o_busy && n < 2000) begin
      n++;
      cycle();
      chk("busy_mis", {31'h0, o_misaligned}, 32'h0);
      i_addr = 32'h13;
      if (n > 3) i_mem_write = 1'b0;
    end
    i_mem_write = 1'b0;
    chk("clear_busy_cycles", n, 256);
    chk("clear_hold", o_wb_read_data, exp_rd);
    for (int i = 0; i < DB; i++) m[i] = 8'h00;
    op("clr_lw10", 0, 1, 32'h10, 0, 3'b001, 0);
    chk("clr_lw10_const", o_wb_read_data, 32'h0);
    op("clr_lw20", 0, 1, 32'h20, 0, 3'b001, 0);
    op("clr_lw04", 0, 1, 32'h04, 0, 3'b001, 0);
    for (int k = 0; k < 16; k++) op("clr_scan", 0, 1, 32'(4 * k), 0, 3'b001, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
